c5g_housekeeping_debug_jtag_host: RTL and testbench

C5G_HOUSEKEEPING_DEBUG_JTAG_HOST -- requirements
Module: c5g_housekeeping_debug_jtag_host

---
 rtl/c5g_housekeeping_debug_jtag_host_pkg.sv | 27 ++
 rtl/c5g_housekeeping_debug_tck_gen.sv | 46 ++++
 rtl/c5g_housekeeping_debug_jtag_host.sv | 161 ++++++++++++++++
 tb/tb_c5g_housekeeping_debug_jtag_host.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/c5g_housekeeping_debug_jtag_host_pkg.sv
`default_nettype none
// ============================================================================
// Module      : c5g_housekeeping_debug_jtag_host_pkg
// Description : Shared debug definitions: host FSM states, scan length and
//               the virtual IR codes understood by the debug slave.
// Revision    : 1.0 - initial release
// ============================================================================
package c5g_housekeeping_debug_jtag_host_pkg;

    localparam int c_scan_len = 38;

    localparam logic [1:0] c_ir_ocimem    = 2'd0;
    localparam logic [1:0] c_ir_trace     = 2'd1;
    localparam logic [1:0] c_ir_break     = 2'd2;
    localparam logic [1:0] c_ir_tracectrl = 2'd3;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_UIR  = 3'd1,
        ST_CDR  = 3'd2,
        ST_SDR  = 3'd3,
        ST_E1DR = 3'd4,
        ST_DONE = 3'd5
    } jtag_state_e;

endpackage
`default_nettype wire

// File: rtl/c5g_housekeeping_debug_tck_gen.sv
`default_nettype none
// ============================================================================
// Module      : c5g_housekeeping_debug_tck_gen
// Description : Free-running TCK divider with strobes that fire in the clk
//               cycle whose closing edge makes TCK rise or fall.
// Revision    : 1.0 - initial release
// ============================================================================
module c5g_housekeeping_debug_tck_gen #(
    parameter int TCK_DIV = 2
) (
    input  logic clk,
    input  logic reset_n,
    input  logic en,
    output logic tck,
    output logic rise_stb,
    output logic fall_stb
);

    logic [7:0] r_cnt;
    logic       r_tck;
    logic       w_last;

    assign w_last = (r_cnt == 8'(TCK_DIV - 1));

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_cnt <= 8'd0;
            r_tck <= 1'b0;
        end else if (!en) begin
            r_cnt <= 8'd0;
            r_tck <= 1'b0;
        end else if (w_last) begin
            r_cnt <= 8'd0;
            r_tck <= ~r_tck;
        end else begin
            r_cnt <= r_cnt + 8'd1;
        end
    end

    // Strobes lead the TCK edge so consumers register in lock-step with it.
    assign tck      = r_tck;
    assign rise_stb = en && w_last && !r_tck;
    assign fall_stb = en && w_last &&  r_tck;

endmodule
`default_nettype wire

// File: rtl/c5g_housekeeping_debug_jtag_host.sv
`default_nettype none
// ============================================================================
// Module      : c5g_housekeeping_debug_jtag_host
// Description : Virtual-JTAG host that runs one UIR/CDR/SDR/E1DR DR scan per
//               accepted command and returns the captured TDO data.
// Revision    : 1.0 - initial release
// ============================================================================
module c5g_housekeeping_debug_jtag_host
    import c5g_housekeeping_debug_jtag_host_pkg::*;
#(
    parameter int TCK_DIV  = 2,
    parameter int SCAN_LEN = c_scan_len
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                cmd_valid,
    output logic                cmd_ready,
    input  logic [1:0]          cmd_ir,
    input  logic [SCAN_LEN-1:0] cmd_data,
    output logic                rsp_valid,
    output logic [SCAN_LEN-1:0] rsp_data,
    output logic                vji_tck,
    output logic                vji_tdi,
    output logic                vji_rti,
    output logic                vji_uir,
    output logic                vji_cdr,
    output logic                vji_sdr,
    output logic                vji_e1dr,
    output logic [1:0]          vji_ir_in,
    input  logic                vji_tdo
);

    jtag_state_e         r_state;
    jtag_state_e         w_next;
    logic                w_tck_en;
    logic                w_rise;
    logic                w_fall;
    logic                w_accept;
    logic                w_last_bit;

    logic                r_armed;
    logic                r_tdi;
    logic                r_rti;
    logic                r_uir;
    logic                r_cdr;
    logic                r_sdr;
    logic                r_e1dr;
    logic                r_rsp_valid;
    logic [1:0]          r_ir;
    logic [5:0]          r_bit_cnt;
    logic [SCAN_LEN-1:0] r_shift;
    logic [SCAN_LEN-1:0] r_capture;
    logic [SCAN_LEN-1:0] r_rsp_data;

    assign cmd_ready  = r_armed && (r_state == ST_IDLE);
    assign w_accept   = cmd_valid && cmd_ready;
    assign w_last_bit = (r_bit_cnt == 6'(SCAN_LEN));
    assign w_tck_en   = (r_state == ST_UIR) || (r_state == ST_CDR) ||
                        (r_state == ST_SDR) || (r_state == ST_E1DR);

    c5g_housekeeping_debug_tck_gen #(
        .TCK_DIV (TCK_DIV)
    ) u_tck_gen (
        .clk      (clk),
        .reset_n  (reset_n),
        .en       (w_tck_en),
        .tck      (vji_tck),
        .rise_stb (w_rise),
        .fall_stb (w_fall)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE: if (w_accept)               w_next = ST_UIR;
            ST_UIR:  if (w_fall)                 w_next = ST_CDR;
            ST_CDR:  if (w_fall)                 w_next = ST_SDR;
            ST_SDR:  if (w_fall && w_last_bit)   w_next = ST_E1DR;
            ST_E1DR: if (w_fall)                 w_next = ST_DONE;
            ST_DONE:                             w_next = ST_IDLE;
            default:                             w_next = ST_IDLE;
        endcase
    end

    // State flags follow the next state, so they move only on TCK falls,
    // on accept, or on DONE->IDLE (where none of them changes).
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_armed     <= 1'b0;
            r_tdi       <= 1'b0;
            r_rti       <= 1'b1;
            r_uir       <= 1'b0;
            r_cdr       <= 1'b0;
            r_sdr       <= 1'b0;
            r_e1dr      <= 1'b0;
            r_rsp_valid <= 1'b0;
            r_ir        <= 2'd0;
            r_bit_cnt   <= 6'd0;
            r_shift     <= '0;
            r_capture   <= '0;
            r_rsp_data  <= '0;
        end else begin
            r_armed     <= 1'b1;
            r_rsp_valid <= 1'b0;
            r_rti       <= (w_next == ST_IDLE) || (w_next == ST_DONE);
            r_uir       <= (w_next == ST_UIR);
            r_cdr       <= (w_next == ST_CDR);
            r_sdr       <= (w_next == ST_SDR);
            r_e1dr      <= (w_next == ST_E1DR);

            if (w_accept) begin
                r_ir      <= cmd_ir;
                r_shift   <= cmd_data;
                r_bit_cnt <= 6'd0;
            end

            if ((r_state == ST_CDR) && w_fall) begin
                r_tdi <= r_shift[0];
            end

            if ((r_state == ST_SDR) && w_rise) begin
                r_capture <= {vji_tdo, r_capture[SCAN_LEN-1:1]};
                r_bit_cnt <= r_bit_cnt + 6'd1;
            end

            if ((r_state == ST_SDR) && w_fall) begin
                if (w_last_bit) begin
                    r_tdi <= 1'b0;
                end else begin
                    r_shift <= {1'b0, r_shift[SCAN_LEN-1:1]};
                    r_tdi   <= r_shift[1];
                end
            end

            if ((r_state == ST_E1DR) && w_fall) begin
                r_rsp_valid <= 1'b1;
                r_rsp_data  <= r_capture;
            end
        end
    end

    assign rsp_valid = r_rsp_valid;
    assign rsp_data  = r_rsp_data;
    assign vji_tdi   = r_tdi;
    assign vji_rti   = r_rti;
    assign vji_uir   = r_uir;
    assign vji_cdr   = r_cdr;
    assign vji_sdr   = r_sdr;
    assign vji_e1dr  = r_e1dr;
    assign vji_ir_in = r_ir;

endmodule
`default_nettype wire

// File: tb/tb_c5g_housekeeping_debug_jtag_host.sv
`default_nettype none
// ============================================================================
// Module      : tb_c5g_housekeeping_debug_jtag_host
// Description : Directed bench with a cycle-level scan-timeline model for the
//               TCK_DIV=2 host and literal checks for a TCK_DIV=1 host.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_c5g_housekeeping_debug_jtag_host;
    import c5g_housekeeping_debug_jtag_host_pkg::*;

    localparam int D    = 2;
    localparam int L    = c_scan_len;
    localparam int LAT  = (L + 3) * 2 * D + 1;
    localparam int LAT1 = (L + 3) * 2 + 1;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         reset_n = 1'b0;
    logic         cmd_valid, cmd_ready, rsp_valid;
    logic [1:0]   cmd_ir, vji_ir_in;
    logic [L-1:0] cmd_data, rsp_data;
    logic         vji_tck, vji_tdi, vji_rti, vji_uir, vji_cdr, vji_sdr, vji_e1dr, vji_tdo;
    int           tdo_mode;

    logic         cmd_valid_1, cmd_ready_1, rsp_valid_1;
    logic [1:0]   cmd_ir_1, vji_ir_in_1;
    logic [L-1:0] cmd_data_1, rsp_data_1;
    logic         vji_tck_1, vji_tdi_1, vji_rti_1, vji_uir_1, vji_cdr_1, vji_sdr_1, vji_e1dr_1;

    assign vji_tdo = (tdo_mode == 0) ? vji_tdi : (tdo_mode == 1);

    c5g_housekeeping_debug_jtag_host #(.TCK_DIV(D), .SCAN_LEN(L)) dut (
        .clk(clk), .reset_n(reset_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_ir(cmd_ir), .cmd_data(cmd_data), .rsp_valid(rsp_valid), .rsp_data(rsp_data),
        .vji_tck(vji_tck), .vji_tdi(vji_tdi), .vji_rti(vji_rti), .vji_uir(vji_uir),
        .vji_cdr(vji_cdr), .vji_sdr(vji_sdr), .vji_e1dr(vji_e1dr),
        .vji_ir_in(vji_ir_in), .vji_tdo(vji_tdo)
    );

    c5g_housekeeping_debug_jtag_host #(.TCK_DIV(1), .SCAN_LEN(L)) dut1 (
        .clk(clk), .reset_n(reset_n), .cmd_valid(cmd_valid_1), .cmd_ready(cmd_ready_1),
        .cmd_ir(cmd_ir_1), .cmd_data(cmd_data_1), .rsp_valid(rsp_valid_1), .rsp_data(rsp_data_1),
        .vji_tck(vji_tck_1), .vji_tdi(vji_tdi_1), .vji_rti(vji_rti_1), .vji_uir(vji_uir_1),
        .vji_cdr(vji_cdr_1), .vji_sdr(vji_sdr_1), .vji_e1dr(vji_e1dr_1),
        .vji_ir_in(vji_ir_in_1), .vji_tdo(vji_tdi_1)
    );

    int n_chk  = 0;
    int n_pass = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 'h%0h, want 'h%0h (t=%0t)", name, act, exp, $time);
    endtask

    // Event monitors; only these processes write their counters.
    int sdr_rises  = 0;
    int accepts    = 0;
    int rsp_pulses = 0;
    int tog_seen   = 0;
    int tog_bad    = 0;
    logic prev_busy1 = 1'b0;
    logic prev_tck1  = 1'b0;

    always @(posedge vji_tck) if (vji_sdr) sdr_rises++;

    always @(negedge clk) begin
        if (reset_n && cmd_valid && cmd_ready) accepts++;
        if (rsp_valid) rsp_pulses++;
        if (!vji_rti_1 && prev_busy1) begin
            tog_seen++;
            if (vji_tck_1 == prev_tck1) tog_bad++;
        end
        prev_busy1 = !vji_rti_1;
        prev_tck1  = vji_tck_1;
    end

    // Timeline model: k counts clk cycles since the accept cycle; each TCK
    // period is 2*D cycles and period p selects UIR, CDR, SDR bits, E1DR.
    int           k     = -1;
    bit           armed = 1'b0;
    logic [1:0]   m_ir  = 2'd0;
    logic [L-1:0] m_data = '0;
    logic [L-1:0] m_rsp  = '0;
    int           m_mode = 0;

    always @(negedge clk) begin
        int       p;
        bit       busy;
        logic     e_tdi;
        logic     e_tck;
        bit       in_scan;
        logic [8:0] e_ctl;
        busy = 1'b0;
        if (!reset_n) begin
            k     = -1;
            armed = 1'b0;
            m_ir  = 2'd0;
            m_rsp = '0;
            e_ctl = 9'b001000000;
        end else begin
            busy    = (k >= 1);
            p       = busy ? (k - 1) / (2 * D) : -1;
            in_scan = (p >= 0) && (p <= L + 2);
            e_tdi   = 1'b0;
            if (p >= 2 && p <= L + 1) e_tdi = m_data[p - 2];
            e_tck   = in_scan ? ((((k - 1) / D) % 2) == 1) : 1'b0;
            if (k == LAT) m_rsp = (m_mode == 0) ? m_data : (m_mode == 1) ? {L{1'b1}} : '0;
            e_ctl = {e_tck, e_tdi, !in_scan, p == 0, p == 1, (p >= 2 && p <= L + 1),
                     p == L + 2, armed && !busy, k == LAT};
        end
        check("ctl{tck,tdi,rti,uir,cdr,sdr,e1dr,ready,valid}",
              {55'd0, vji_tck, vji_tdi, vji_rti, vji_uir, vji_cdr, vji_sdr, vji_e1dr,
               cmd_ready, rsp_valid}, {55'd0, e_ctl});
        check("ir_in", {62'd0, vji_ir_in}, {62'd0, m_ir});
        check("rsp_data", {26'd0, rsp_data}, {26'd0, m_rsp});
        if (reset_n) begin
            if (!busy && armed && cmd_valid) begin
                k      = 1;
                m_ir   = cmd_ir;
                m_data = cmd_data;
                m_mode = tdo_mode;
            end else if (busy) begin
                k++;
                if (k > LAT) k = -1;
            end
            armed = 1'b1;
        end
    end

    task automatic start_scan(input logic [1:0] ir, input logic [L-1:0] d, input int mode);
        for (int i = 0; i < 400 && !cmd_ready; i++) begin
            @(posedge clk); #1;
        end
        cmd_ir    = ir;
        cmd_data  = d;
        tdo_mode  = mode;
        cmd_valid = 1'b1;
        @(posedge clk); #1;
        cmd_valid = 1'b0;
    endtask

    task automatic wait_rsp(output int lat);
        lat = 1;
        while (!rsp_valid && lat < 400) begin
            @(posedge clk); #1;
            lat++;
        end
    endtask

    initial begin
        int lat;
        int base;
        int seen;
        cmd_valid   = 1'b0; cmd_ir   = 2'd0; cmd_data   = '0; tdo_mode = 0;
        cmd_valid_1 = 1'b0; cmd_ir_1 = 2'd0; cmd_data_1 = '0;

        repeat (3) @(posedge clk);
        #1;
        check("rst_ready", {63'd0, cmd_ready}, 64'd0);
        check("rst_rti", {63'd0, vji_rti}, 64'd1);
        check("rst_rsp", {26'd0, rsp_data}, 64'd0);
        reset_n = 1'b1;
        @(posedge clk); #1;
        check("ready_after_rst", {63'd0, cmd_ready}, 64'd1);

        // Loopback, IR=BREAK, exact latency and pulse width
        start_scan(c_ir_break, 38'h2A_5555_AAAA, 0);
        check("uir_ir", {61'd0, vji_uir, vji_ir_in}, 64'b110);
        wait_rsp(lat);
        check("latency", lat, LAT);
        check("loop_rsp", {26'd0, rsp_data}, {26'd0, 38'h2A_5555_AAAA});
        @(posedge clk); #1;
        check("valid_width", {63'd0, rsp_valid}, 64'd0);
        check("rsp_hold", {26'd0, rsp_data}, {26'd0, 38'h2A_5555_AAAA});

        // TDO tied high; count SDR rises
        base = sdr_rises;
        start_scan(c_ir_tracectrl, '0, 1);
        wait_rsp(lat);
        check("ones_rsp", {26'd0, rsp_data}, {26'd0, 38'h3F_FFFF_FFFF});
        check("sdr_rises", sdr_rises - base, 64'd38);

        start_scan(c_ir_ocimem, 38'h01_2345_6789, 0);
        wait_rsp(lat);
        check("loop_rsp2", {26'd0, rsp_data}, {26'd0, 38'h01_2345_6789});

        // cmd_valid held across two scans
        for (int i = 0; i < 400 && !cmd_ready; i++) begin
            @(posedge clk); #1;
        end
        base      = accepts;
        cmd_ir    = c_ir_trace;
        cmd_data  = 38'h33_0000_FFFF;
        tdo_mode  = 0;
        cmd_valid = 1'b1;
        seen      = 0;
        for (int i = 0; i < 600 && seen < 2; i++) begin
            @(posedge clk); #1;
            if (rsp_valid) seen++;
        end
        cmd_valid = 1'b0;
        check("held_rsp_count", seen, 64'd2);
        check("held_accepts", accepts - base, 64'd2);

        // Reset on the 10th SDR rise
        base = sdr_rises;
        start_scan(c_ir_break, 38'h15_0F0F_F0F0, 0);
        for (int i = 0; i < 400 && (sdr_rises - base) < 10; i++) begin
            @(posedge clk); #1;
        end
        reset_n = 1'b0;
        #1;
        check("mid_rst_rises", sdr_rises - base, 64'd10);
        check("mid_rst_ctl", {55'd0, vji_tck, vji_tdi, vji_rti, vji_uir, vji_cdr, vji_sdr,
              vji_e1dr, cmd_ready, rsp_valid}, 64'b001000000);
        check("mid_rst_ir", {62'd0, vji_ir_in}, 64'd0);
        check("mid_rst_rsp", {26'd0, rsp_data}, 64'd0);
        base = rsp_pulses;
        repeat (3) @(posedge clk);
        #1;
        reset_n = 1'b1;
        repeat (200) @(posedge clk);
        #1;
        check("no_rsp_after_rst", rsp_pulses - base, 64'd0);
        start_scan(c_ir_trace, 38'h2B_CDEF_0123, 0);
        wait_rsp(lat);
        check("post_rst_latency", lat, LAT);
        check("post_rst_rsp", {26'd0, rsp_data}, {26'd0, 38'h2B_CDEF_0123});

        // TCK_DIV=1 instance, loopback
        for (int i = 0; i < 400 && !cmd_ready_1; i++) begin
            @(posedge clk); #1;
        end
        cmd_ir_1    = c_ir_break;
        cmd_data_1  = 38'h15_A5A5_3C3C;
        cmd_valid_1 = 1'b1;
        @(posedge clk); #1;
        cmd_valid_1 = 1'b0;
        lat = 1;
        while (!rsp_valid_1 && lat < 400) begin
            @(posedge clk); #1;
            lat++;
        end
        check("div1_latency", lat, LAT1);
        check("div1_rsp", {26'd0, rsp_data_1}, {26'd0, 38'h15_A5A5_3C3C});
        check("div1_toggle_cycles", tog_seen, 64'd81);
        check("div1_toggle_misses", tog_bad, 64'd0);

        @(posedge clk); #1;
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
`default_nettype wire
